// File: rtl/control_pipe_unit.sv
// Control path of a classic 5-stage MIPS-style pipeline: ID decode, ID/EX,
// EX/MEM and MEM/WB control registers, hazard detection, operand-forwarding
// selects, branch/jump resolution in EX, memory-wait freeze and sticky halt.

package cpu_types_pkg;
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03, OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e,
        OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b, OP_HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20,
        FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
        FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a,
        FN_SLTU = 6'h2b
    } funct_t;

    // ADD is encoded as zero so an all-zero bubble carries ALU op ADD
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3,
        ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
        ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_LUI = 4'd10
    } aluop_t;
endpackage

module control_pipe_unit
    import cpu_types_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter int ALUOP_W = 4
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [31:0]        instr,
    input  logic               id_valid,
    input  logic               alu_zero,
    input  logic               dmem_ready,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               mem_memren,
    output logic               mem_memwr,
    output logic               wb_regwr,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_wsel,
    output logic               stall,
    output logic               flush,
    output logic               pc_src,
    output logic               halt
);

    // src_a/src_b are zero when the instruction does not read that operand,
    // so hazard and forwarding logic never has to know the instruction class.
    typedef struct packed {
        logic              regwr;
        logic              memtoreg;
        logic              memren;
        logic              memwr;
        logic              alu_src;
        logic              beq;
        logic              bne;
        logic              jump;
        logic              halt;
        aluop_t            alu_op;
        logic [REG_AW-1:0] wsel;
        logic [REG_AW-1:0] src_a;
        logic [REG_AW-1:0] src_b;
    } ex_ctrl_t;

    typedef struct packed {
        logic              regwr;
        logic              memtoreg;
        logic              memren;
        logic              memwr;
        logic              halt;
        logic [REG_AW-1:0] wsel;
    } mem_ctrl_t;

    typedef struct packed {
        logic              regwr;
        logic              memtoreg;
        logic              halt;
        logic [REG_AW-1:0] wsel;
    } wb_ctrl_t;

    ex_ctrl_t  dec;
    ex_ctrl_t  ex_q, ex_d;
    mem_ctrl_t mem_q, mem_d;
    wb_ctrl_t  wb_q, wb_d;
    logic      halt_q, halt_d;

    logic [5:0]        opcode, funct;
    logic [REG_AW-1:0] rs, rt, rd;
    logic              taken, mem_wait, hazard, raw_ex, raw_mem;
    logic              unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign rs           = REG_AW'(instr[25:21]);
    assign rt           = REG_AW'(instr[20:16]);
    assign rd           = REG_AW'(instr[15:11]);
    assign unused_shamt = ^instr[10:6];

    // A nonzero source register that matches a producer's destination
    function automatic logic src_hit(input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    // Newest producer wins: MEM result over WB result, otherwise register file
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input mem_ctrl_t m, input wb_ctrl_t w);
        if (!FWD_EN)                          return 2'b00;
        if (m.regwr && src_hit(src, m.wsel))  return 2'b01;
        if (w.regwr && src_hit(src, w.wsel))  return 2'b10;
        return 2'b00;
    endfunction

    // ID decode; unknown encodings, invalid slots and post-halt fetches are bubbles
    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.regwr = 1'b1;
                dec.wsel  = rd;
                dec.src_a = rs;
                dec.src_b = rt;
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:          dec.alu_op = ALU_AND;
                    FN_OR:           dec.alu_op = ALU_OR;
                    FN_XOR:          dec.alu_op = ALU_XOR;
                    FN_NOR:          dec.alu_op = ALU_NOR;
                    FN_SLT:          dec.alu_op = ALU_SLT;
                    FN_SLTU:         dec.alu_op = ALU_SLTU;
                    FN_SLL:          dec.alu_op = ALU_SLL;
                    FN_SRL:          dec.alu_op = ALU_SRL;
                    FN_JR: begin
                        dec.regwr = 1'b0;
                        dec.wsel  = '0;
                        dec.src_b = '0;
                        dec.jump  = 1'b1;
                    end
                    default:         dec = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.regwr   = 1'b1;
                dec.alu_src = 1'b1;
                dec.wsel    = rt;
                dec.src_a   = (opcode == OP_LUI) ? '0 : rs;
                case (opcode)
                    OP_SLTI:  dec.alu_op = ALU_SLT;
                    OP_SLTIU: dec.alu_op = ALU_SLTU;
                    OP_ANDI:  dec.alu_op = ALU_AND;
                    OP_ORI:   dec.alu_op = ALU_OR;
                    OP_XORI:  dec.alu_op = ALU_XOR;
                    OP_LUI:   dec.alu_op = ALU_LUI;
                    default:  dec.alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                dec.regwr    = 1'b1;
                dec.memtoreg = 1'b1;
                dec.memren   = 1'b1;
                dec.alu_src  = 1'b1;
                dec.wsel     = rt;
                dec.src_a    = rs;
            end
            OP_SW: begin
                dec.memwr   = 1'b1;
                dec.alu_src = 1'b1;
                dec.src_a   = rs;
                dec.src_b   = rt;
            end
            OP_BEQ, OP_BNE: begin
                dec.beq    = (opcode == OP_BEQ);
                dec.bne    = (opcode == OP_BNE);
                dec.alu_op = ALU_SUB;
                dec.src_a  = rs;
                dec.src_b  = rt;
            end
            OP_J:    dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump  = 1'b1;
                dec.regwr = 1'b1;
                dec.wsel  = {REG_AW{1'b1}};
            end
            OP_HALT: dec.halt = 1'b1;
            default: dec = '0;
        endcase
        if (dec.wsel == '0)
            dec.regwr = 1'b0;
        if (!id_valid || halt)
            dec = '0;
    end

    // Hazards, branch resolution and next-state for each stage register
    always_comb begin
        raw_ex  = ex_q.regwr  && (src_hit(dec.src_a, ex_q.wsel)  || src_hit(dec.src_b, ex_q.wsel));
        raw_mem = mem_q.regwr && (src_hit(dec.src_a, mem_q.wsel) || src_hit(dec.src_b, mem_q.wsel));
        hazard  = FWD_EN ? (raw_ex && ex_q.memren) : (raw_ex || raw_mem);
        taken   = (ex_q.beq && alu_zero) || (ex_q.bne && !alu_zero) || ex_q.jump;
        mem_wait = (mem_q.memren || mem_q.memwr) && !dmem_ready;

        // Killed (flush) or held-back (hazard) ID slots both become a bubble in EX
        ex_d  = (taken || hazard) ? '0 : dec;
        mem_d = '{regwr: ex_q.regwr, memtoreg: ex_q.memtoreg, memren: ex_q.memren,
                  memwr: ex_q.memwr, halt: ex_q.halt, wsel: ex_q.wsel};
        wb_d  = '{regwr: mem_q.regwr, memtoreg: mem_q.memtoreg, halt: mem_q.halt,
                  wsel: mem_q.wsel};
        halt_d = halt_q || wb_q.halt;
    end

    // Stage registers: reset clears to bubbles, a memory wait freezes the pipe
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
            if (!mem_wait) begin
                ex_q  <= ex_d;
                mem_q <= mem_d;
                wb_q  <= wb_d;
            end
        end
    end

    assign ex_alu_op   = ALUOP_W'(ex_q.alu_op);
    assign ex_alu_src  = ex_q.alu_src;
    assign fwd_a       = fwd_sel(ex_q.src_a, mem_q, wb_q);
    assign fwd_b       = fwd_sel(ex_q.src_b, mem_q, wb_q);
    assign mem_memren  = mem_q.memren;
    assign mem_memwr   = mem_q.memwr;
    // A frozen WB slot must not write again on every waiting cycle
    assign wb_regwr    = wb_q.regwr && !mem_wait;
    assign wb_memtoreg = wb_q.memtoreg;
    assign wb_wsel     = wb_q.wsel;
    assign flush       = taken && !mem_wait;
    assign pc_src      = flush;
    assign stall       = mem_wait || (hazard && !taken);
    assign halt        = halt_q || wb_q.halt;

endmodule

// File: tb/tb_control_pipe_unit.sv
// Bench for control_pipe_unit: dut0 forwards (FWD_EN=1), dut1 stalls on every
// RAW (FWD_EN=0). Register writes are scoreboarded per DUT; timing-specific
// behaviour is checked inline cycle by cycle.
module tb_control_pipe_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] instr0, instr1;
    logic        id_valid0, id_valid1;
    logic        alu_zero, dmem_ready;

    logic [3:0] ex_alu_op0, ex_alu_op1;
    logic       ex_alu_src0, ex_alu_src1;
    logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic       mem_memren0, mem_memwr0, mem_memren1, mem_memwr1;
    logic       wb_regwr0, wb_memtoreg0, wb_regwr1, wb_memtoreg1;
    logic [4:0] wb_wsel0, wb_wsel1;
    logic       stall0, flush0, pc_src0, halt0;
    logic       stall1, flush1, pc_src1, halt1;

    int checks = 0;
    int failures = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    always #5 CLK = ~CLK;

    control_pipe_unit #(.REG_AW(5), .FWD_EN(1'b1), .ALUOP_W(4)) dut0 (
        .CLK(CLK), .nRST(nRST), .instr(instr0), .id_valid(id_valid0),
        .alu_zero(alu_zero), .dmem_ready(dmem_ready),
        .ex_alu_op(ex_alu_op0), .ex_alu_src(ex_alu_src0),
        .fwd_a(fwd_a0), .fwd_b(fwd_b0),
        .mem_memren(mem_memren0), .mem_memwr(mem_memwr0),
        .wb_regwr(wb_regwr0), .wb_memtoreg(wb_memtoreg0), .wb_wsel(wb_wsel0),
        .stall(stall0), .flush(flush0), .pc_src(pc_src0), .halt(halt0));

    control_pipe_unit #(.REG_AW(5), .FWD_EN(1'b0), .ALUOP_W(4)) dut1 (
        .CLK(CLK), .nRST(nRST), .instr(instr1), .id_valid(id_valid1),
        .alu_zero(alu_zero), .dmem_ready(dmem_ready),
        .ex_alu_op(ex_alu_op1), .ex_alu_src(ex_alu_src1),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .mem_memren(mem_memren1), .mem_memwr(mem_memwr1),
        .wb_regwr(wb_regwr1), .wb_memtoreg(wb_memtoreg1), .wb_wsel(wb_wsel1),
        .stall(stall1), .flush(flush1), .pc_src(pc_src1), .halt(halt1));

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic drv0(input logic [31:0] ins, input logic v);
        instr0 = ins; id_valid0 = v;
    endtask
    task automatic drv1(input logic [31:0] ins, input logic v);
        instr1 = ins; id_valid1 = v;
    endtask
    task automatic idle(input int n);
        drv0(32'h0, 1'b0); drv1(32'h0, 1'b0);
        repeat (n) step();
    endtask

    // Write-back scoreboard: every wb_regwr pulse consumes one expected destination
    always @(negedge CLK) begin : sb_mon
        logic [4:0] e;
        if (wb_regwr0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL sb0_write got wsel=%0d required no write", wb_wsel0);
            end else begin
                e = q0.pop_front();
                if (wb_wsel0 !== e) begin
                    failures++;
                    $display("FAIL sb0_wsel got=%0d required=%0d", wb_wsel0, e);
                end
            end
        end
        if (wb_regwr1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL sb1_write got wsel=%0d required no write", wb_wsel1);
            end else begin
                e = q1.pop_front();
                if (wb_wsel1 !== e) begin
                    failures++;
                    $display("FAIL sb1_wsel got=%0d required=%0d", wb_wsel1, e);
                end
            end
        end
    end

    task automatic test_reset();
        nRST = 1'b0; alu_zero = 1'b0; dmem_ready = 1'b1;
        drv0(enc_i(OP_LW, 5'd1, 5'd2, 16'h0), 1'b1);
        drv1(enc_i(OP_LW, 5'd1, 5'd2, 16'h0), 1'b1);
        step(); step();
        @(negedge CLK);
        checks++;
        if ({stall0, flush0, pc_src0, halt0, fwd_a0, fwd_b0, mem_memren0, mem_memwr0,
             wb_regwr0, wb_memtoreg0, wb_wsel0} !== 18'h0) begin
            failures++;
            $display("FAIL reset_out0 got=%h required=0", {stall0, flush0, pc_src0, halt0,
                     fwd_a0, fwd_b0, mem_memren0, mem_memwr0, wb_regwr0, wb_memtoreg0, wb_wsel0});
        end
        checks++;
        if ({stall1, flush1, pc_src1, halt1, fwd_a1, fwd_b1, mem_memren1, mem_memwr1,
             wb_regwr1, wb_memtoreg1, wb_wsel1} !== 18'h0) begin
            failures++;
            $display("FAIL reset_out1 got=%h required=0", {stall1, flush1, pc_src1, halt1,
                     fwd_a1, fwd_b1, mem_memren1, mem_memwr1, wb_regwr1, wb_memtoreg1, wb_wsel1});
        end
        nRST = 1'b1;
        idle(2);
    endtask

    task automatic test_load_use();
        drv0(enc_i(OP_LW, 5'd1, 5'd2, 16'h0), 1'b1); q0.push_back(5'd2);
        step();
        drv0(enc_r(FN_ADD, 5'd2, 5'd4, 5'd3), 1'b1); q0.push_back(5'd3);
        @(negedge CLK);
        checks++;
        if (stall0 !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b required=1", stall0); end
        checks++;
        if ({ex_alu_src0, ex_alu_op0} !== {1'b1, 4'(ALU_ADD)}) begin
            failures++; $display("FAIL lu_ex_lw got=%b required=10000", {ex_alu_src0, ex_alu_op0});
        end
        step();
        @(negedge CLK);
        checks++;
        if ({stall0, mem_memren0} !== 2'b01) begin
            failures++; $display("FAIL lu_release got=%b required=01", {stall0, mem_memren0});
        end
        step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({fwd_a0, fwd_b0, wb_memtoreg0} !== 5'b10001) begin
            failures++; $display("FAIL lu_fwd got=%b required=10001", {fwd_a0, fwd_b0, wb_memtoreg0});
        end
        step(); step();
        @(negedge CLK);
        checks++;
        if ({wb_regwr0, wb_wsel0} !== {1'b1, 5'd3}) begin
            failures++; $display("FAIL lu_wb got=%b required=100011", {wb_regwr0, wb_wsel0});
        end
        idle(3);
        checks++;
        if (q0.size() != 0) begin failures++; $display("FAIL lu_drain got=%0d required=0", q0.size()); end
    endtask

    task automatic test_forward();
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd5), 1'b1); q0.push_back(5'd5);
        step();
        drv0(enc_r(FN_SUB, 5'd5, 5'd5, 5'd6), 1'b1); q0.push_back(5'd6);
        @(negedge CLK);
        checks++;
        if (stall0 !== 1'b0) begin failures++; $display("FAIL fw_nostall got=%0b required=0", stall0); end
        step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({fwd_a0, fwd_b0, ex_alu_op0} !== {4'b0101, 4'(ALU_SUB)}) begin
            failures++; $display("FAIL fw_mem got=%b required=01010001", {fwd_a0, fwd_b0, ex_alu_op0});
        end
        idle(3);
        // Two producers of $7 in flight: MEM copy must win over WB copy
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd7), 1'b1); q0.push_back(5'd7); step();
        drv0(enc_r(FN_ADD, 5'd3, 5'd4, 5'd7), 1'b1); q0.push_back(5'd7); step();
        drv0(enc_r(FN_OR,  5'd7, 5'd7, 5'd8), 1'b1); q0.push_back(5'd8); step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({fwd_a0, fwd_b0} !== 4'b0101) begin
            failures++; $display("FAIL fw_prio got=%b required=0101", {fwd_a0, fwd_b0});
        end
        idle(4);
        // Producer only in WB, consumer reads it on rt
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd9), 1'b1); q0.push_back(5'd9); step();
        drv0(32'h0, 1'b0); step();
        drv0(enc_r(FN_AND, 5'd1, 5'd9, 5'd10), 1'b1); q0.push_back(5'd10); step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({fwd_a0, fwd_b0} !== 4'b0010) begin
            failures++; $display("FAIL fw_wb got=%b required=0010", {fwd_a0, fwd_b0});
        end
        idle(4);
        checks++;
        if (q0.size() != 0) begin failures++; $display("FAIL fw_drain got=%0d required=0", q0.size()); end
    endtask

    task automatic test_fwd_off();
        drv1(enc_r(FN_ADD, 5'd1, 5'd2, 5'd5), 1'b1); q1.push_back(5'd5);
        step();
        drv1(enc_r(FN_SUB, 5'd5, 5'd5, 5'd6), 1'b1); q1.push_back(5'd6);
        @(negedge CLK);
        checks++;
        if (stall1 !== 1'b1) begin failures++; $display("FAIL nf_stall1 got=%0b required=1", stall1); end
        step();
        @(negedge CLK);
        checks++;
        if (stall1 !== 1'b1) begin failures++; $display("FAIL nf_stall2 got=%0b required=1", stall1); end
        step();
        @(negedge CLK);
        checks++;
        if (stall1 !== 1'b0) begin failures++; $display("FAIL nf_release got=%0b required=0", stall1); end
        step();
        drv1(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({fwd_a1, fwd_b1, ex_alu_op1} !== {4'b0000, 4'(ALU_SUB)}) begin
            failures++; $display("FAIL nf_ex got=%b required=00000001", {fwd_a1, fwd_b1, ex_alu_op1});
        end
        idle(4);
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL nf_drain got=%0d required=0", q1.size()); end
    endtask

    task automatic test_branch();
        drv0(enc_i(OP_BEQ, 5'd1, 5'd2, 16'h4), 1'b1); step();
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd11), 1'b1); alu_zero = 1'b1;
        @(negedge CLK);
        checks++;
        if ({pc_src0, flush0, stall0} !== 3'b110) begin
            failures++; $display("FAIL br_taken got=%b required=110", {pc_src0, flush0, stall0});
        end
        step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({pc_src0, flush0} !== 2'b00) begin
            failures++; $display("FAIL br_once got=%b required=00", {pc_src0, flush0});
        end
        step();
        alu_zero = 1'b0;
        drv0(enc_i(OP_BNE, 5'd1, 5'd2, 16'h4), 1'b1); step();
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd12), 1'b1); q0.push_back(5'd12); alu_zero = 1'b1;
        @(negedge CLK);
        checks++;
        if ({pc_src0, flush0} !== 2'b00) begin
            failures++; $display("FAIL bne_not_taken got=%b required=00", {pc_src0, flush0});
        end
        step();
        alu_zero = 1'b0;
        drv0(enc_r(FN_JR, 5'd1, 5'd0, 5'd0), 1'b1); step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({pc_src0, flush0} !== 2'b11) begin
            failures++; $display("FAIL jr_taken got=%b required=11", {pc_src0, flush0});
        end
        idle(4);
        // Flush and RAW hazard together on the stalling variant: flush wins
        drv1(enc_j(OP_JAL, 26'h10), 1'b1); q1.push_back(5'd31); step();
        drv1(enc_r(FN_ADD, 5'd31, 5'd0, 5'd13), 1'b1);
        @(negedge CLK);
        checks++;
        if ({pc_src1, flush1, stall1} !== 3'b110) begin
            failures++; $display("FAIL jal_flush got=%b required=110", {pc_src1, flush1, stall1});
        end
        idle(5);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            failures++; $display("FAIL br_drain got=%0d required=0", q0.size() + q1.size());
        end
    endtask

    task automatic test_mem_wait();
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd14), 1'b1); q0.push_back(5'd14); step();
        drv0(enc_i(OP_SW, 5'd1, 5'd2, 16'h8), 1'b1); step();
        drv0(32'h0, 1'b0); step();
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd15), 1'b1); q0.push_back(5'd15);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({stall0, mem_memwr0, wb_regwr0} !== 3'b110) begin
                failures++; $display("FAIL mw_wait%0d got=%b required=110", i, {stall0, mem_memwr0, wb_regwr0});
            end
            step();
        end
        dmem_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if ({stall0, mem_memwr0, wb_regwr0} !== 3'b011) begin
            failures++; $display("FAIL mw_done got=%b required=011", {stall0, mem_memwr0, wb_regwr0});
        end
        step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if (mem_memwr0 !== 1'b0) begin failures++; $display("FAIL mw_advance got=%0b required=0", mem_memwr0); end
        idle(4);
        checks++;
        if (q0.size() != 0) begin failures++; $display("FAIL mw_drain got=%0d required=0", q0.size()); end
    endtask

    task automatic test_reset_mid();
        drv0(enc_i(OP_LW, 5'd1, 5'd2, 16'h0), 1'b1); step();
        drv0(enc_r(FN_ADD, 5'd2, 5'd4, 5'd3), 1'b1);
        @(negedge CLK);
        checks++;
        if (stall0 !== 1'b1) begin failures++; $display("FAIL rm_pre_stall got=%0b required=1", stall0); end
        nRST = 1'b0;
        step();
        nRST = 1'b1; drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({stall0, mem_memren0, wb_regwr0} !== 3'b000) begin
            failures++; $display("FAIL rm_stall_clr got=%b required=000", {stall0, mem_memren0, wb_regwr0});
        end
        step();
        drv0(enc_i(OP_SW, 5'd1, 5'd2, 16'h0), 1'b1); step();
        drv0(32'h0, 1'b0); step();
        dmem_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (stall0 !== 1'b1) begin failures++; $display("FAIL rm_pre_wait got=%0b required=1", stall0); end
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({stall0, mem_memwr0} !== 2'b00) begin
            failures++; $display("FAIL rm_wait_clr got=%b required=00", {stall0, mem_memwr0});
        end
        dmem_ready = 1'b1;
        idle(3);
    endtask

    task automatic test_halt();
        drv0(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd5), 1'b1); step();
        drv0(enc_j(OP_HALT, 26'h0), 1'b1); step();
        drv0(32'h0, 1'b0);
        @(negedge CLK);
        checks++;
        if (halt0 !== 1'b0) begin failures++; $display("FAIL ht_early1 got=%0b required=0", halt0); end
        step();
        @(negedge CLK);
        checks++;
        if ({halt0, wb_regwr0} !== 2'b00) begin
            failures++; $display("FAIL ht_r0 got=%b required=00", {halt0, wb_regwr0});
        end
        step();
        @(negedge CLK);
        checks++;
        if (halt0 !== 1'b1) begin failures++; $display("FAIL ht_set got=%0b required=1", halt0); end
        step();
        // Fetches after halt become bubbles; the scoreboard rejects any write
        drv0(enc_r(FN_ADD, 5'd1, 5'd2, 5'd16), 1'b1);
        repeat (4) step();
        @(negedge CLK);
        checks++;
        if ({halt0, ex_alu_src0, mem_memren0} !== 3'b100) begin
            failures++; $display("FAIL ht_sticky got=%b required=100", {halt0, ex_alu_src0, mem_memren0});
        end
        nRST = 1'b0; drv0(32'h0, 1'b0);
        step();
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (halt0 !== 1'b0) begin failures++; $display("FAIL ht_clear got=%0b required=0", halt0); end
        idle(2);
        checks++;
        if (q0.size() != 0) begin failures++; $display("FAIL ht_drain got=%0d required=0", q0.size()); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_fwd_off();
        test_branch();
        test_mem_wait();
        test_reset_mid();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
